pipelined_addsub: RTL and testbench

//  Parametrised, pipelined add/subtract unit; successor to the single-cycle 32-bit combinational adder.

---
 rtl/alu_pkg.sv | 18 +
 rtl/addsub_stage.sv | 88 ++++++++
 rtl/pipelined_addsub.sv | 118 +++++++++++
 tb/tb_pipelined_addsub.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes and ALU status flags for the add/subtract datapath.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

endpackage

// File: rtl/addsub_stage.sv
// One carry segment of the pipelined adder: adds the low SegBits of the incoming operands,
// shifts the result segment in from the top, and holds or advances under valid/ready flow control.
module addsub_stage
  import alu_pkg::*;
#(
  parameter int unsigned NrOfBits   = 32,
  parameter int unsigned SegBits    = 8,
  parameter int unsigned StageIdx   = 0,
  parameter int unsigned NrOfStages = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic                i_adv_next,
  output logic                o_adv,
  output logic                o_valid,
  input  logic [NrOfBits-1:0] i_a,
  input  logic [NrOfBits-1:0] i_b,
  input  logic [NrOfBits-1:0] i_res,
  input  logic                i_carry,
  input  logic                i_zero,
  output logic [NrOfBits-1:0] o_a,
  output logic [NrOfBits-1:0] o_b,
  output logic [NrOfBits-1:0] o_res,
  output logic                o_carry,
  output logic                o_zero,
  output logic                o_cmsb
);

  localparam bit Last = (StageIdx == NrOfStages - 1);

  logic                r_valid;
  logic [NrOfBits-1:0] r_a;
  logic [NrOfBits-1:0] r_b;
  logic [NrOfBits-1:0] r_res;
  logic                r_carry;
  logic                r_zero;
  logic                r_cmsb;

  logic [SegBits-1:0]  w_a_seg;
  logic [SegBits-1:0]  w_b_seg;
  logic [SegBits:0]    w_seg;
  logic                w_cmsb;

  assign w_a_seg = i_a[SegBits-1:0];
  assign w_b_seg = i_b[SegBits-1:0];
  assign w_seg   = {1'b0, w_a_seg} + {1'b0, w_b_seg} + {{SegBits{1'b0}}, i_carry};
  // Carry into the segment MSB recovered from its sum bit; only meaningful in the last stage.
  assign w_cmsb  = w_seg[SegBits-1] ^ w_a_seg[SegBits-1] ^ w_b_seg[SegBits-1];

  assign o_adv   = !r_valid || i_adv_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (o_adv) begin
      r_valid <= i_valid;
    end
  end

  // Operands shift down a segment per stage; result segments enter from the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_cmsb  <= 1'b0;
    end else if (o_adv && i_valid) begin
      r_a     <= i_a >> SegBits;
      r_b     <= i_b >> SegBits;
      r_res   <= (i_res >> SegBits) | (NrOfBits'(w_seg[SegBits-1:0]) << (NrOfBits - SegBits));
      r_carry <= w_seg[SegBits];
      r_zero  <= i_zero && (w_seg[SegBits-1:0] == '0);
      r_cmsb  <= Last ? w_cmsb : 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_res   = r_res;
  assign o_carry = r_carry;
  assign o_zero  = r_zero;
  assign o_cmsb  = r_cmsb;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: carry chain split into NrOfStages segments with
// per-stage valid/ready flow control, bubble collapsing and ALU status flags.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int unsigned NrOfBits   = 32,
  parameter int unsigned NrOfStages = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic                in_cin,
  input  logic [NrOfBits-1:0] in_a,
  input  logic [NrOfBits-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NrOfBits-1:0] out_result,
  output logic                out_carry,
  output logic                out_ovf,
  output logic                out_zero,
  output logic                out_neg
);

  localparam int unsigned SegBits = NrOfBits / NrOfStages;

  op_e                 w_op;
  logic [NrOfBits-1:0] w_b_eff;
  logic                w_c0;
  flags_t              w_flags;

  logic                w_valid [0:NrOfStages];
  logic                w_adv   [0:NrOfStages];
  logic [NrOfBits-1:0] w_a     [0:NrOfStages];
  logic [NrOfBits-1:0] w_b     [0:NrOfStages];
  logic [NrOfBits-1:0] w_res   [0:NrOfStages];
  logic                w_carry [0:NrOfStages];
  logic                w_zero  [0:NrOfStages];
  logic                w_cmsb  [0:NrOfStages-1];

  assign w_op = op_e'(in_op);

  always_comb begin
    w_b_eff = in_b;
    w_c0    = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_b_eff = in_b;
        w_c0    = 1'b0;
      end
      OP_SUB: begin
        w_b_eff = ~in_b;
        w_c0    = 1'b1;
      end
      OP_ADC: begin
        w_b_eff = in_b;
        w_c0    = in_cin;
      end
      OP_SBB: begin
        w_b_eff = ~in_b;
        w_c0    = in_cin;
      end
    endcase
  end

  assign w_valid[0]          = in_valid;
  assign w_a[0]              = in_a;
  assign w_b[0]              = w_b_eff;
  assign w_res[0]            = '0;
  assign w_carry[0]          = w_c0;
  assign w_zero[0]           = 1'b1;
  assign w_adv[NrOfStages]   = out_ready;
  assign in_ready            = w_adv[0];

  for (genvar k = 0; k < NrOfStages; k++) begin : g_stage
    addsub_stage #(
      .NrOfBits  (NrOfBits),
      .SegBits   (SegBits),
      .StageIdx  (k),
      .NrOfStages(NrOfStages)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .i_valid   (w_valid[k]),
      .i_adv_next(w_adv[k+1]),
      .o_adv     (w_adv[k]),
      .o_valid   (w_valid[k+1]),
      .i_a       (w_a[k]),
      .i_b       (w_b[k]),
      .i_res     (w_res[k]),
      .i_carry   (w_carry[k]),
      .i_zero    (w_zero[k]),
      .o_a       (w_a[k+1]),
      .o_b       (w_b[k+1]),
      .o_res     (w_res[k+1]),
      .o_carry   (w_carry[k+1]),
      .o_zero    (w_zero[k+1]),
      .o_cmsb    (w_cmsb[k])
    );
  end

  always_comb begin
    w_flags       = '0;
    w_flags.carry = w_carry[NrOfStages];
    w_flags.ovf   = w_carry[NrOfStages] ^ w_cmsb[NrOfStages-1];
    w_flags.zero  = w_zero[NrOfStages];
    w_flags.neg   = w_res[NrOfStages][NrOfBits-1];
  end

  assign out_valid  = w_valid[NrOfStages];
  assign out_result = w_res[NrOfStages];
  assign out_carry  = w_flags.carry;
  assign out_ovf    = w_flags.ovf;
  assign out_zero   = w_flags.zero;
  assign out_neg    = w_flags.neg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed and stream tests for pipelined_addsub with a full-width reference model.
module tb_pipelined_addsub;

  localparam int unsigned BITS = 32;
  parameter int unsigned STAGES = 4;

  typedef struct packed {
    logic [BITS-1:0] res;
    logic            c;
    logic            v;
    logic            z;
    logic            n;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic            in_cin;
  logic [BITS-1:0] in_a;
  logic [BITS-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_result;
  logic            out_carry;
  logic            out_ovf;
  logic            out_zero;
  logic            out_neg;
  exp_t            w_obs;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_addsub #(.NrOfBits(BITS), .NrOfStages(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_cin    (in_cin),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_neg   (out_neg)
  );

  assign w_obs = {out_result, out_carry, out_ovf, out_zero, out_neg};

  function automatic exp_t model(input logic [1:0] op, input logic cin,
                                 input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    exp_t            e;
    logic [BITS-1:0] bb;
    logic            c0;
    logic [BITS:0]   s;
    bb    = op[0] ? ~b : b;
    c0    = op[1] ? cin : op[0];
    s     = {1'b0, a} + {1'b0, bb} + {{BITS{1'b0}}, c0};
    e.res = s[BITS-1:0];
    e.c   = s[BITS];
    e.v   = (a[BITS-1] == bb[BITS-1]) && (e.res[BITS-1] != a[BITS-1]);
    e.z   = (e.res == '0);
    e.n   = e.res[BITS-1];
    return e;
  endfunction

  task automatic drive(input logic [1:0] op, input logic cin,
                       input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    in_op    = op;
    in_cin   = cin;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
  endtask

  task automatic drive_rand(output exp_t e);
    logic [1:0]      op;
    logic            cin;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    op  = 2'($urandom_range(0, 3));
    cin = 1'($urandom_range(0, 1));
    a   = $urandom;
    b   = $urandom;
    if ($urandom_range(0, 7) == 0) b = ~a;
    if ($urandom_range(0, 7) == 0) b = a;
    drive(op, cin, a, b);
    e = model(op, cin, a, b);
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_cin    = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (w_obs !== exp_t'('0)) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", w_obs);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single(input string name, input logic [1:0] op, input logic cin,
                             input logic [BITS-1:0] a, input logic [BITS-1:0] b, input exp_t e);
    int lat;
    @(negedge clk);
    drive(op, cin, a, b);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready);
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk) in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < int'(STAGES) + 5) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_checks++;
    if (out_valid !== 1'b1 || lat != int'(STAGES)) begin
      n_fail++; $display("FAIL %s_latency: got %0d (valid %b) expected %0d", name, lat, out_valid, STAGES);
    end
    n_checks++;
    if (w_obs !== e) begin
      n_fail++;
      $display("FAIL %s_value: got res=%h c%b v%b z%b n%b expected res=%h c%b v%b z%b n%b",
               name, w_obs.res, w_obs.c, w_obs.v, w_obs.z, w_obs.n, e.res, e.c, e.v, e.z, e.n);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_drain: got valid %b expected 0", name, out_valid);
    end
  endtask

  task automatic test_directed;
    test_single("add_5_7",   2'b00, 1'b0, 32'd5,        32'd7, '{res: 32'd12,        c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0});
    test_single("sub_5_7",   2'b01, 1'b0, 32'd5,        32'd7, '{res: 32'hFFFFFFFE,  c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b1});
    test_single("sub_min_1", 2'b01, 1'b0, 32'h80000000, 32'd1, '{res: 32'h7FFFFFFF,  c: 1'b1, v: 1'b1, z: 1'b0, n: 1'b0});
    test_single("add_wrap",  2'b00, 1'b0, 32'hFFFFFFFF, 32'd1, '{res: 32'h00000000,  c: 1'b1, v: 1'b0, z: 1'b1, n: 1'b0});
    test_single("adc_ffff",  2'b10, 1'b1, 32'h0000FFFF, 32'd0, '{res: 32'h00010000,  c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0});
    test_single("sbb_nb",    2'b11, 1'b1, 32'd10,       32'd3, '{res: 32'd7,         c: 1'b1, v: 1'b0, z: 1'b0, n: 1'b0});
    test_single("sbb_b",     2'b11, 1'b0, 32'd10,       32'd3, '{res: 32'd6,         c: 1'b1, v: 1'b0, z: 1'b0, n: 1'b0});
    test_single("add_ovf",   2'b00, 1'b0, 32'h7FFFFFFF, 32'd1, '{res: 32'h80000000,  c: 1'b0, v: 1'b1, z: 1'b0, n: 1'b1});
  endtask

  task automatic test_back_to_back;
    int got   = 0;
    int first = -1;
    int last  = -1;
    int stall = 0;
    exp_q.delete();
    out_ready = 1'b1;
    fork
      begin
        exp_t e;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          drive_rand(e);
          #1;
          if (in_ready !== 1'b1) stall++;
          exp_q.push_back(e);
        end
        @(negedge clk) in_valid = 1'b0;
      end
      begin
        exp_t e;
        for (int c = 0; c < 100 + int'(STAGES) + 10 && got < 100; c++) begin
          @(negedge clk);
          #2;
          if (out_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL b2b_extra: unexpected beat res=%h", w_obs.res);
            end else begin
              e = exp_q.pop_front();
              if (w_obs !== e) begin
                n_fail++; $display("FAIL b2b_beat%0d: got %h expected %h", got, w_obs, e);
              end
            end
            if (first < 0) first = c;
            last = c;
            got++;
          end
        end
      end
    join
    n_checks++;
    if (got != 100 || stall != 0) begin
      n_fail++; $display("FAIL b2b_count: got %0d beats, %0d stalls, expected 100 beats, 0 stalls", got, stall);
    end
    n_checks++;
    if (last - first != 99) begin
      n_fail++; $display("FAIL b2b_rate: got span %0d expected 99", last - first);
    end
  endtask

  task automatic test_backpressure;
    int   acc    = 0;
    int   got    = 0;
    bit   stable = 1'b1;
    exp_t e;
    exp_t snap;
    exp_q.delete();
    @(negedge clk) out_ready = 1'b0;
    for (int c = 0; c < int'(STAGES) + 3; c++) begin
      @(negedge clk);
      drive_rand(e);
      #1;
      if (in_ready === 1'b1) begin
        exp_q.push_back(e);
        acc++;
      end
    end
    @(negedge clk) in_valid = 1'b0;
    #1;
    n_checks++;
    if (acc != int'(STAGES) || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_fill: got %0d accepts, in_ready %b expected %0d accepts, in_ready 0", acc, in_ready, STAGES);
    end
    snap = w_obs;
    n_checks++;
    if (out_valid !== 1'b1 || exp_q.size() == 0 || snap !== exp_q[0]) begin
      n_fail++; $display("FAIL bp_head: got valid %b res %h expected valid 1 and oldest beat", out_valid, snap.res);
    end
    repeat (10) begin
      @(negedge clk);
      #1;
      if (w_obs !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    n_checks++;
    if (!stable) begin
      n_fail++; $display("FAIL bp_stable: got %h expected held %h", w_obs, snap);
    end
    for (int c = 0; c < int'(STAGES) + 5; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_dup: unexpected beat res=%h", w_obs.res);
        end else begin
          e = exp_q.pop_front();
          if (w_obs !== e) begin
            n_fail++; $display("FAIL bp_beat%0d: got %h expected %h", got, w_obs, e);
          end
        end
        got++;
      end
    end
    n_checks++;
    if (got != int'(STAGES) || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_drain: got %0d beats expected %0d", got, STAGES);
    end
  endtask

  task automatic test_bubbles;
    int sent     = 0;
    int got      = 0;
    bit drv_done = 1'b0;
    exp_q.delete();
    fork
      begin
        exp_t e;
        for (int c = 0; c < 24; c++) begin
          @(negedge clk);
          out_ready = (c % 3 != 2);
          if (c % 2 == 0) drive_rand(e);
          else in_valid = 1'b0;
          #1;
          if (in_valid === 1'b1 && in_ready === 1'b1) begin
            exp_q.push_back(e);
            sent++;
          end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drv_done  = 1'b1;
      end
      begin
        exp_t e;
        for (int c = 0; c < 24 + 4 * int'(STAGES) + 20; c++) begin
          @(negedge clk);
          #2;
          if (drv_done && exp_q.size() == 0 && out_valid !== 1'b1) break;
          if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL bub_extra: unexpected beat res=%h", w_obs.res);
            end else begin
              e = exp_q.pop_front();
              if (w_obs !== e) begin
                n_fail++; $display("FAIL bub_beat%0d: got %h expected %h", got, w_obs, e);
              end
            end
            got++;
          end
        end
      end
    join
    n_checks++;
    if (got != sent || sent != 12) begin
      n_fail++; $display("FAIL bub_count: got %0d delivered of %0d sent expected 12 of 12", got, sent);
    end
  endtask

  task automatic test_reset_midstream;
    int   acc   = 0;
    bit   stale = 1'b0;
    exp_t e;
    int   want;
    want = (STAGES < 3) ? int'(STAGES) : 3;
    @(negedge clk) out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_rand(e);
      #1;
      if (in_ready === 1'b1) acc++;
    end
    @(negedge clk) in_valid = 1'b0;
    n_checks++;
    if (acc != want) begin
      n_fail++; $display("FAIL rstm_fill: got %0d accepts expected %0d", acc, want);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstm_async: got valid %b expected 0", out_valid);
    end
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (w_obs !== exp_t'('0) || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstm_clear: got res %h valid %b in_ready %b expected 0/0/1", w_obs, out_valid, in_ready);
    end
    repeat (2 * STAGES + 4) begin
      @(negedge clk);
      if (out_valid === 1'b1) stale = 1'b1;
    end
    n_checks++;
    if (stale) begin
      n_fail++; $display("FAIL rstm_stale: got a beat after reset expected none");
    end
    test_single("post_rst", 2'b00, 1'b0, 32'd1, 32'd1, '{res: 32'd2, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
